// File: rtl/led_display_updown_counter.sv
// rtl/led_display_updown_counter.sv - programmable-rate up/down display counter with update and wrap strobes
// Optional: define LED_DISPLAY_COUNTER_SATURATE_EN to hold at the terminals instead of wrapping.
module led_display_updown_counter #(
  parameter int WIDTH          = 16,
  parameter int MAX_VALUE      = (1 << WIDTH) - 1,
  parameter int TICK_DIV_RATE  = 12_500_000,
  parameter int TICK_DIV_WIDTH = 24
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_enable,
  input  logic             i_dir,
  input  logic             i_clear_stb,
  input  logic             i_load_stb,
  input  logic [WIDTH-1:0] i_load_value,
  output logic [WIDTH-1:0] o_count,
  output logic             o_update_stb,
  output logic             o_wrap,
  output logic             o_running
);

  typedef enum logic [1:0] {
    ST_RESET        = 2'd0,
    ST_INIT         = 2'd1,
    ST_WAIT_STARTUP = 2'd2,
    ST_COUNT        = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0]          MAX_V     = WIDTH'(MAX_VALUE);
  localparam logic [TICK_DIV_WIDTH-1:0] TICK_LAST = TICK_DIV_WIDTH'(TICK_DIV_RATE - 1);

  state_t                    state_q, state_d;
  logic [TICK_DIV_WIDTH-1:0] presc_q, presc_d;
  logic [WIDTH-1:0]          count_q, count_d;
  logic                      update_q, update_d;
  logic                      wrap_q, wrap_d;

  logic             run_state;
  logic             active;
  logic             tick;
  logic             tick_eff;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] step_val;
  logic             step_wrap;

  assign run_state    = (state_q == ST_WAIT_STARTUP) || (state_q == ST_COUNT);
  assign active       = run_state && i_enable;
  assign tick         = active && (presc_q == TICK_LAST);
  // Strobes take the edge away from the tick, so a discarded tick never advances the FSM.
  assign tick_eff     = tick && !i_clear_stb && !i_load_stb;
  assign load_clamped = (i_load_value > MAX_V) ? MAX_V : i_load_value;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:        state_d = ST_INIT;
      ST_INIT:         state_d = ST_WAIT_STARTUP;
      ST_WAIT_STARTUP: if (tick_eff) state_d = ST_COUNT;
      ST_COUNT:        state_d = ST_COUNT;
      default:         state_d = ST_RESET;
    endcase
  end

  always_comb begin
    o_running    = (state_q == ST_COUNT) && i_enable;
    o_count      = count_q;
    o_update_stb = update_q;
    o_wrap       = wrap_q;
  end

  always_comb begin
    step_val  = count_q;
    step_wrap = 1'b0;
    if (i_dir) begin
      if (count_q >= MAX_V) begin
`ifdef LED_DISPLAY_COUNTER_SATURATE_EN
        step_val  = MAX_V;
`else
        step_val  = '0;
        step_wrap = 1'b1;
`endif
      end else begin
        step_val = count_q + WIDTH'(1);
      end
    end else begin
      if (count_q == '0) begin
`ifdef LED_DISPLAY_COUNTER_SATURATE_EN
        step_val  = '0;
`else
        step_val  = MAX_V;
        step_wrap = 1'b1;
`endif
      end else begin
        step_val = count_q - WIDTH'(1);
      end
    end
  end

  always_comb begin
    presc_d = presc_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    if (state_q == ST_INIT) begin
      presc_d = '0;
      count_d = '0;
    end else if (run_state) begin
      if (tick) begin
        presc_d = '0;
      end else if (active) begin
        presc_d = presc_q + TICK_DIV_WIDTH'(1);
      end
      if (i_clear_stb) begin
        presc_d = '0;
        count_d = '0;
      end else if (i_load_stb) begin
        count_d = load_clamped;
      end else if (tick && (state_q == ST_COUNT)) begin
        count_d = step_val;
        wrap_d  = step_wrap;
      end
    end
    // Only a real change of value is announced to the display controller.
    update_d = (count_d != count_q);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      presc_q  <= '0;
      count_q  <= '0;
      update_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      count_q  <= count_d;
      update_q <= update_d;
      wrap_q   <= wrap_d;
    end
  end

endmodule
